// File: rtl/wb_master.sv
// Wishbone classic single-transfer master.
// Takes one user request at a time, runs it as a single CYC/STB bus cycle,
// and holds the outcome (read data or error/timeout) until the user
// consumes it.
module wb_master #(
    parameter int TIMEOUT = 16,
    parameter int TW      = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    // user request channel
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [3:0]  req_sel_i,
    input  logic [31:0] req_adr_i,
    input  logic [31:0] req_dat_i,
    // user response channel
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,
    output logic        busy_o,
    // Wishbone master side
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    input  logic [31:0] wbm_dat_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Last timer value before the transfer is abandoned.
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next;
    logic        r_we;
    logic [3:0]  r_sel;
    logic [31:0] r_adr;
    logic [31:0] r_dat;
    logic [TW-1:0] r_timer;
    logic [31:0] r_rsp_dat;
    logic        r_rsp_err;
    logic        w_timeout;

    assign w_timeout = (r_timer == TMAX);

    // State register; reset forces IDLE, dropping any bus cycle or pending response.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and output decode; bus and response outputs are zero outside their states.
    always_comb begin
        w_next      = r_state;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        rsp_dat_o   = 32'd0;
        rsp_err_o   = 1'b0;
        busy_o      = 1'b1;
        wbm_cyc_o   = 1'b0;
        wbm_stb_o   = 1'b0;
        wbm_we_o    = 1'b0;
        wbm_sel_o   = 4'd0;
        wbm_adr_o   = 32'd0;
        wbm_dat_o   = 32'd0;
        case (r_state)
            S_IDLE: begin
                req_ready_o = 1'b1;
                busy_o      = 1'b0;
                if (req_valid_i) begin
                    w_next = S_BUS;
                end
            end
            S_BUS: begin
                wbm_cyc_o = 1'b1;
                wbm_stb_o = 1'b1;
                wbm_we_o  = r_we;
                wbm_sel_o = r_sel;
                wbm_adr_o = r_adr;
                wbm_dat_o = r_dat;
                // ack, err and timeout all end the cycle; which one only matters for the response
                if (wbm_ack_i || wbm_err_i || w_timeout) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid_o = 1'b1;
                rsp_dat_o   = r_rsp_dat;
                rsp_err_o   = r_rsp_err;
                if (rsp_ready_i) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Request latch, bus timer and response capture. Err beats ack, and either beats timeout.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            r_timer <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        r_we    <= req_we_i;
                        r_sel   <= req_sel_i;
                        r_adr   <= req_adr_i;
                        r_dat   <= req_dat_i;
                        r_timer <= '0;
                    end
                end
                S_BUS: begin
                    if (wbm_err_i) begin
                        r_rsp_err <= 1'b1;
                        r_rsp_dat <= 32'd0;
                    end else if (wbm_ack_i) begin
                        r_rsp_err <= 1'b0;
                        r_rsp_dat <= r_we ? 32'd0 : wbm_dat_i;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                        if (w_timeout) begin
                            r_rsp_err <= 1'b1;
                            r_rsp_dat <= 32'd0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_master.sv
// Self-checking bench for wb_master: fixed vector table, hand-written
// reset/backpressure sequences, and randomized transfers against a
// transfer-level reference model.
module tb_wb_master;

    localparam int TIMEOUT = 16;
    localparam int K_ACK  = 0;
    localparam int K_ERR  = 1;
    localparam int K_BOTH = 2;
    localparam int K_NONE = 3;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_n_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [3:0]  req_sel_i = 4'd0;
    logic [31:0] req_adr_i = 32'd0;
    logic [31:0] req_dat_i = 32'd0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_dat_o;
    logic        rsp_err_o;
    logic        busy_o;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic        wbm_ack_i = 1'b0;
    logic        wbm_err_i = 1'b0;
    logic [31:0] wbm_dat_i = 32'd0;

    int checks = 0;
    int errors = 0;

    wb_master #(.TIMEOUT(TIMEOUT), .TW(8)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_n_i(wb_rst_n_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_we_i(req_we_i), .req_sel_i(req_sel_i),
        .req_adr_i(req_adr_i), .req_dat_i(req_dat_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o), .busy_o(busy_o),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_dat_i(wbm_dat_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
        int          kind;
        int          wt;
        logic [31:0] rdata;
        logic [31:0] exp_dat;
        logic        exp_err;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Transfer-level model: which event ends the cycle and what the user sees.
    task automatic model(input logic we, input int kind, input int wt, input logic [31:0] rdata,
                         output logic [31:0] dat, output logic err, output int cyc);
        if (kind == K_NONE || wt >= TIMEOUT) begin
            dat = 32'd0; err = 1'b1; cyc = TIMEOUT;
        end else if (kind == K_ERR || kind == K_BOTH) begin
            dat = 32'd0; err = 1'b1; cyc = wt + 1;
        end else begin
            dat = we ? 32'd0 : rdata; err = 1'b0; cyc = wt + 1;
        end
    endtask

    // Issue one request at a negedge in IDLE and play the slave until the
    // response appears. Returns at a negedge with the response showing.
    task automatic run_bus(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                           input logic [31:0] dat, input int kind, input int wt,
                           input logic [31:0] rdata,
                           output int cyc_cnt, output int lat, output bit bad, output bit hung);
        int idx;
        cyc_cnt = 0; lat = 0; bad = 0; hung = 1;
        req_valid_i = 1'b1; req_we_i = we; req_sel_i = sel; req_adr_i = adr; req_dat_i = dat;
        if (req_ready_o !== 1'b1) bad = 1;
        @(negedge wb_clk_i);
        req_valid_i = 1'b0;
        req_dat_i = $urandom;
        req_adr_i = $urandom;
        for (int n = 0; n < 300; n++) begin
            lat++;
            if (wbm_cyc_o === 1'b1) begin
                cyc_cnt++;
                idx = cyc_cnt - 1;
                if (wbm_stb_o !== 1'b1 || wbm_we_o !== we || wbm_sel_o !== sel ||
                    wbm_adr_o !== adr || wbm_dat_o !== dat || req_ready_o !== 1'b0 ||
                    busy_o !== 1'b1 || rsp_valid_o !== 1'b0) bad = 1;
                if (idx == wt && kind != K_NONE) begin
                    wbm_ack_i = (kind == K_ACK || kind == K_BOTH);
                    wbm_err_i = (kind == K_ERR || kind == K_BOTH);
                    wbm_dat_i = rdata;
                end else begin
                    wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_dat_i = $urandom;
                end
            end else begin
                wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
                if (rsp_valid_o === 1'b1) begin
                    if (wbm_stb_o !== 1'b0 || wbm_we_o !== 1'b0 || wbm_sel_o !== 4'd0 ||
                        wbm_adr_o !== 32'd0 || wbm_dat_o !== 32'd0 || req_ready_o !== 1'b0 ||
                        busy_o !== 1'b1) bad = 1;
                    hung = 0;
                    break;
                end
            end
            @(negedge wb_clk_i);
        end
    endtask

    task automatic consume(input string name);
        rsp_ready_i = 1'b1;
        @(negedge wb_clk_i);
        rsp_ready_i = 1'b0;
        chk({name, " idle_ready"}, {29'd0, req_ready_o, rsp_valid_o, busy_o}, 32'h4);
    endtask

    task automatic run_and_check(input string name, input logic we, input logic [3:0] sel,
                                 input logic [31:0] adr, input logic [31:0] dat, input int kind,
                                 input int wt, input logic [31:0] rdata,
                                 input logic [31:0] exp_dat, input logic exp_err, input int exp_cyc);
        int cc, lt;
        bit bad, hung;
        run_bus(we, sel, adr, dat, kind, wt, rdata, cc, lt, bad, hung);
        chk({name, " no_hang"}, {31'd0, hung}, 32'd0);
        chk({name, " rsp_dat"}, rsp_dat_o, exp_dat);
        chk({name, " rsp_err"}, {31'd0, rsp_err_o}, {31'd0, exp_err});
        chk({name, " cyc_cycles"}, cc, exp_cyc);
        chk({name, " latency"}, lt, exp_cyc + 1);
        chk({name, " bus_fields"}, {31'd0, bad}, 32'd0);
        consume(name);
    endtask

    initial begin
        logic [31:0] m_dat;
        logic        m_err;
        int          m_cyc;

        // fields: we sel adr dat kind wait rdata | exp_dat exp_err exp_cyc
        vecs[0] = '{1'b1, 4'hF, 32'h3000_0000, 32'hA5A5_1234, K_ACK, 1, 32'hDEAD_BEEF, 32'h0, 1'b0, 2};
        vecs[1] = '{1'b0, 4'hF, 32'h3000_0004, 32'h0, K_ACK, 0, 32'h0000_00FF, 32'h0000_00FF, 1'b0, 1};
        vecs[2] = '{1'b0, 4'hF, 32'h3000_0008, 32'h0, K_NONE, 0, 32'h1111_1111, 32'h0, 1'b1, 16};
        vecs[3] = '{1'b0, 4'h3, 32'h3000_000C, 32'h0, K_ACK, 15, 32'h1234_5678, 32'h1234_5678, 1'b0, 16};
        vecs[4] = '{1'b0, 4'hF, 32'h3000_0010, 32'h0, K_BOTH, 3, 32'hFFFF_FFFF, 32'h0, 1'b1, 4};
        vecs[5] = '{1'b0, 4'h1, 32'h3000_0014, 32'h0, K_ERR, 0, 32'h5555_AAAA, 32'h0, 1'b1, 1};
        vecs[6] = '{1'b1, 4'hC, 32'h3000_0018, 32'h0BAD_F00D, K_ERR, 2, 32'h7777_7777, 32'h0, 1'b1, 3};
        vecs[7] = '{1'b0, 4'hF, 32'h3000_001C, 32'h0, K_ACK, 16, 32'h9999_9999, 32'h0, 1'b1, 16};

        // reset state
        repeat (3) @(negedge wb_clk_i);
        chk("reset ready", {31'd0, req_ready_o}, 32'd1);
        chk("reset ctl", {27'd0, rsp_valid_o, rsp_err_o, busy_o, wbm_cyc_o, wbm_stb_o}, 32'd0);
        chk("reset bus", {wbm_adr_o ^ wbm_dat_o ^ rsp_dat_o} | {27'd0, wbm_sel_o, wbm_we_o}, 32'd0);
        wb_rst_n_i = 1'b1;
        @(negedge wb_clk_i);

        for (int i = 0; i < 8; i++) begin
            run_and_check($sformatf("vec%0d", i), vecs[i].we, vecs[i].sel, vecs[i].adr,
                          vecs[i].dat, vecs[i].kind, vecs[i].wt, vecs[i].rdata,
                          vecs[i].exp_dat, vecs[i].exp_err, vecs[i].exp_cyc);
        end

        // backpressure: response held, new request waiting, no second bus cycle
        begin
            int cc, lt;
            bit bad, hung, held_bad;
            run_bus(1'b0, 4'hF, 32'h4000_0000, 32'h0, K_ACK, 0, 32'hCAFE_0001, cc, lt, bad, hung);
            chk("bp no_hang", {31'd0, hung}, 32'd0);
            req_valid_i = 1'b1; req_we_i = 1'b0; req_adr_i = 32'h4000_0100;
            held_bad = 0;
            for (int k = 0; k < 5; k++) begin
                if (rsp_valid_o !== 1'b1 || rsp_dat_o !== 32'hCAFE_0001 || rsp_err_o !== 1'b0 ||
                    req_ready_o !== 1'b0 || wbm_cyc_o !== 1'b0) held_bad = 1;
                @(negedge wb_clk_i);
            end
            chk("bp held", {31'd0, held_bad}, 32'd0);
            rsp_ready_i = 1'b1;
            @(negedge wb_clk_i);
            rsp_ready_i = 1'b0;
            req_valid_i = 1'b0;
            chk("bp released", {29'd0, req_ready_o, rsp_valid_o, wbm_cyc_o}, 32'h4);
            @(negedge wb_clk_i);
            chk("bp no_cyc", {31'd0, wbm_cyc_o}, 32'd0);
        end

        // reset mid-bus with a late ack
        req_valid_i = 1'b1; req_we_i = 1'b0; req_sel_i = 4'hF; req_adr_i = 32'h5000_0000;
        @(negedge wb_clk_i);
        req_valid_i = 1'b0;
        chk("rstbus cyc", {31'd0, wbm_cyc_o}, 32'd1);
        @(negedge wb_clk_i);
        wb_rst_n_i = 1'b0;
        @(negedge wb_clk_i);
        wb_rst_n_i = 1'b1;
        wbm_ack_i = 1'b1; wbm_dat_i = 32'h0000_ABCD;
        chk("rstbus after", {27'd0, req_ready_o, rsp_valid_o, busy_o, wbm_cyc_o, wbm_stb_o}, 32'h10);
        @(negedge wb_clk_i);
        wbm_ack_i = 1'b0;
        chk("rstbus late_ack", {28'd0, req_ready_o, rsp_valid_o, wbm_cyc_o, busy_o}, 32'h8);

        // reset while a response is pending
        begin
            int cc, lt;
            bit bad, hung;
            run_bus(1'b0, 4'hF, 32'h6000_0000, 32'h0, K_ACK, 2, 32'h0F0F_0F0F, cc, lt, bad, hung);
            chk("rstresp pending", rsp_dat_o, 32'h0F0F_0F0F);
            wb_rst_n_i = 1'b0;
            @(negedge wb_clk_i);
            wb_rst_n_i = 1'b1;
            chk("rstresp dropped", {30'd0, req_ready_o, rsp_valid_o}, 32'h2);
            chk("rstresp dat", rsp_dat_o, 32'd0);
            @(negedge wb_clk_i);
            chk("rstresp stays", {31'd0, rsp_valid_o}, 32'd0);
        end

        // randomized transfers against the model
        for (int r = 0; r < 40; r++) begin
            logic        we;
            logic [3:0]  sel;
            logic [31:0] adr, dat, rd;
            int          kind, wt;
            we = 1'($urandom_range(0, 1));
            sel = 4'($urandom);
            adr = $urandom;
            dat = $urandom;
            rd = $urandom;
            kind = $urandom_range(0, 3);
            wt = $urandom_range(0, 20);
            model(we, kind, wt, rd, m_dat, m_err, m_cyc);
            run_and_check($sformatf("rnd%0d", r), we, sel, adr, dat, kind, wt, rd,
                          m_dat, m_err, m_cyc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_master.md
WB_MASTER -- requirements
Module: wb_master

Parameters
REQ-001 The block SHALL have parameter TIMEOUT, default 16, giving the maximum bus cycles a transfer may hold CYC before abort (legal 2..255).
REQ-002 The block SHALL have parameter TW, default 8, giving the timeout counter width.

Interface
REQ-003 wb_clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-004 wb_rst_n_i  input  1  reset, synchronous and active-low.
REQ-005 req_valid_i  input  1  user request present.
REQ-006 req_ready_o  output  1  block accepts request this cycle.
REQ-007 req_we_i  input  1  1 = write, 0 = read.
REQ-008 req_sel_i  input  4  byte lane strobes.
REQ-009 req_adr_i  input  32  byte address.
REQ-010 req_dat_i  input  32  write data.
REQ-011 rsp_valid_o  output  1  response pending.
REQ-012 rsp_ready_i  input  1  user consumes response.
REQ-013 rsp_dat_o  output  32  read data; 0 for writes and errors.
REQ-014 rsp_err_o  output  1  1 = bus error or timeout.
REQ-015 busy_o  output  1  high whenever state is not IDLE.
REQ-016 wbm_cyc_o, wbm_stb_o, wbm_we_o  output  1 each  Wishbone classic master controls.
REQ-017 wbm_sel_o 4, wbm_adr_o 32, wbm_dat_o 32  output  Wishbone master select/address/write data.
REQ-018 wbm_ack_i 1, wbm_err_i 1, wbm_dat_i 32  input  Wishbone slave acknowledge/error/read data.

Function
REQ-019 The block SHALL implement states IDLE, BUS, RESP; one transfer in flight at a time.
REQ-020 IDLE: req_ready_o=1; on edge with req_valid_i=1, latch we/sel/adr/dat, clear timer, go BUS.
REQ-021 req_ready_o SHALL be 0 in BUS and RESP; requests then are not accepted and not lost (user holds valid).
REQ-022 BUS: wbm_cyc_o=wbm_stb_o=1 from the cycle after acceptance; we/sel/adr/dat outputs SHALL be stable for the whole BUS state.
REQ-023 Outside BUS, wbm_cyc_o and wbm_stb_o SHALL be 0; wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o SHALL be 0.
REQ-024 Edge in BUS with wbm_ack_i=1, wbm_err_i=0: go RESP, rsp_err=0, rsp_dat = wbm_dat_i if read else 0.
REQ-025 Edge in BUS with wbm_err_i=1 (regardless of ack): go RESP, rsp_err=1, rsp_dat=0.
REQ-026 Edge in BUS with neither: timer increments; if timer was TIMEOUT-1, go RESP with rsp_err=1, rsp_dat=0 (CYC held exactly TIMEOUT cycles).
REQ-027 Ack/err on the final timeout cycle SHALL take priority over timeout.
REQ-028 wbm_ack_i/wbm_err_i SHALL be ignored in IDLE and RESP.
REQ-029 RESP: rsp_valid_o=1, rsp_dat_o/rsp_err_o stable until edge with rsp_ready_i=1, then go IDLE.
REQ-030 Minimum transfer: accept edge N, CYC during N+1, zero-wait ack sampled at N+2 edge, rsp_valid during N+2, IDLE earliest at N+3 edge.
REQ-031 Timer SHALL be TW bits, saturate-free; TIMEOUT-1 SHALL fit in TW.

Reset
REQ-032 On an edge with wb_rst_n_i=0, state SHALL go IDLE, timer=0, all outputs 0 except req_ready_o=1 in the following cycle.
REQ-033 Reset during BUS SHALL drop CYC/STB at that edge with no response generated; a late ack after reset SHALL be ignored.
REQ-034 Reset during RESP SHALL discard the pending response.

Verification
REQ-035 Write 0xA5A5_1234 to 0x3000_0000, sel 0xF, slave acks 1 cycle after STB -> one CYC window of 2 cycles, rsp_valid with err=0, dat=0.
REQ-036 Read 0x3000_0004, slave returns 0x0000_00FF with zero-wait ack -> rsp_dat=0x0000_00FF, err=0, rsp_valid 2 cycles after accept.
REQ-037 Read with no ack, TIMEOUT=16 -> CYC high exactly 16 cycles, then rsp_err=1, rsp_dat=0; ack on 16th cycle instead -> err=0.
REQ-038 Slave asserts ack and err together -> rsp_err=1, rsp_dat=0.
REQ-039 rsp_ready_i held 0 for 5 cycles with req_valid_i high -> rsp stable, req_ready_o=0, no second CYC until response consumed.
REQ-040 wb_rst_n_i low for 1 cycle mid-BUS, slave acks afterwards -> CYC/STB 0, no rsp_valid, req_ready_o=1.
